// File: rtl/rvv_backend_decode_seq_pkg.sv
// Shared types and sizing for the RVV decode sequencer slice.
package rvv_backend_decode_seq_pkg;

  localparam int NUM_DE_UOP      = 4;
  localparam int UOP_INDEX_WIDTH = 3;
  localparam int UQ_FREE_WIDTH   = 4;
  localparam int DE_CNT_WIDTH    = $clog2(NUM_DE_UOP + 1);

  // Sequencer states kept as plain constants for legacy tooling
  typedef logic [0:0] DE_STATE_e;
  localparam DE_STATE_e DE_IDLE = 1'b0;
  localparam DE_STATE_e DE_MID  = 1'b1;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [2:0] funct3;
    logic [5:0] funct6;
    logic [2:0] vlmul;
  } RVVCmd;

  typedef struct packed {
    logic [6:0]                 opcode;
    logic [4:0]                 vd;
    logic [UOP_INDEX_WIDTH-1:0] uop_index;
    logic                       last;
  } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_backend_decode_seq_cnt.sv
// Counts contiguous valid lanes from lane 0 and clamps the count to the
// free slots of the downstream queue. Purely combinational.
module rvv_backend_decode_seq_cnt
  import rvv_backend_decode_seq_pkg::*;
#(
  parameter int LANES  = NUM_DE_UOP,
  parameter int CNT_W  = DE_CNT_WIDTH,
  parameter int FREE_W = UQ_FREE_WIDTH
) (
  input  logic [LANES-1:0]  lane_valid,
  input  logic [FREE_W-1:0] free,
  output logic [CNT_W-1:0]  n_dec,
  output logic [CNT_W-1:0]  n_push,
  output logic              contiguous
);

  logic             run_s;
  logic [LANES-1:0] mask_s;

  // Count the run of set valid bits starting at lane 0
  always_comb begin
    n_dec = '0;
    run_s = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (run_s && lane_valid[k]) begin
        n_dec = n_dec + CNT_W'(1);
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Rebuild the ideal thermometer mask to detect holes in the valid pattern
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < LANES; k++) begin
      mask_s[k] = (CNT_W'(k) < n_dec);
    end
    contiguous = (mask_s == lane_valid);
  end

  // Clamp the decoded count to the available queue space
  always_comb begin
    if (free < FREE_W'(n_dec)) begin
      n_push = CNT_W'(free);
    end else begin
      n_push = n_dec;
    end
  end

endmodule

// File: rtl/rvv_backend_decode_seq.sv
// Decode sequencer: tracks uop progress of the CQ head instruction, pushes
// decoded uops into the UQ as space allows and pops the CQ on the final uop.
module rvv_backend_decode_seq
  import rvv_backend_decode_seq_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  inst_valid_cq2de,
  input  RVVCmd                                 inst_cq2de,
  output logic                                  pop_de2cq,
  output logic [UOP_INDEX_WIDTH-1:0]            uop_index_remain,
  input  logic [NUM_DE_UOP-1:0]                 dec_uop_valid,
  input  logic [NUM_DE_UOP-1:0]                 dec_uop_last,
  input  UOP_QUEUE_t [NUM_DE_UOP-1:0]           dec_uop,
  input  logic [UQ_FREE_WIDTH-1:0]              uq_free,
  output logic [NUM_DE_UOP-1:0]                 uop_valid_de2uq,
  output UOP_QUEUE_t [NUM_DE_UOP-1:0]           uop_de2uq,
  input  logic                                  trap_flush_rvv,
  output logic                                  busy
);

  logic [UOP_INDEX_WIDTH-1:0] index_r, index_nxt_s;
  DE_STATE_e                  state_r, state_nxt_s;
  RVVCmd                      inst_hold_r, inst_hold_nxt_s;
  logic [DE_CNT_WIDTH-1:0]    n_dec_s, n_push_s;
  logic                       contiguous_s;
  logic                       go_s, done_s, drop_s;
  logic [NUM_DE_UOP-1:0]      push_mask_s;

  rvv_backend_decode_seq_cnt u_cnt (
    .lane_valid (dec_uop_valid),
    .free       (uq_free),
    .n_dec      (n_dec_s),
    .n_push     (n_push_s),
    .contiguous (contiguous_s)
  );

  assign go_s             = inst_valid_cq2de & ~trap_flush_rvv & ~rst;
  assign uop_index_remain = index_r;
  assign busy             = (state_r == DE_MID);

  // Select pushed lanes, detect the final uop and zero-uop drops
  always_comb begin
    push_mask_s = '0;
    for (int k = 0; k < NUM_DE_UOP; k++) begin
      push_mask_s[k] = (DE_CNT_WIDTH'(k) < n_push_s);
    end
    done_s = |(dec_uop_last & push_mask_s);
    drop_s = (n_dec_s == '0) & ~(|dec_uop_last);
  end

  // Drive UQ push and CQ pop; unpushed lanes carry zero
  always_comb begin
    uop_valid_de2uq = '0;
    uop_de2uq       = '0;
    for (int k = 0; k < NUM_DE_UOP; k++) begin
      if (go_s && push_mask_s[k]) begin
        uop_valid_de2uq[k] = 1'b1;
        uop_de2uq[k]       = dec_uop[k];
      end else begin
        uop_valid_de2uq[k] = 1'b0;
        uop_de2uq[k]       = '0;
      end
    end
    pop_de2cq = go_s & (done_s | drop_s);
  end

  // Next index/state; flush wins over completion, absent head holds progress
  always_comb begin
    state_nxt_s     = state_r;
    index_nxt_s     = index_r;
    inst_hold_nxt_s = inst_hold_r;
    if (trap_flush_rvv) begin
      state_nxt_s = DE_IDLE;
      index_nxt_s = '0;
    end else if (!inst_valid_cq2de) begin
      state_nxt_s = state_r;
      index_nxt_s = index_r;
    end else if (done_s || drop_s) begin
      state_nxt_s = DE_IDLE;
      index_nxt_s = '0;
    end else if (n_push_s != '0) begin
      state_nxt_s = DE_MID;
      index_nxt_s = index_r + UOP_INDEX_WIDTH'(n_push_s);
      if (state_r == DE_IDLE) begin
        inst_hold_nxt_s = inst_cq2de;
      end else begin
        inst_hold_nxt_s = inst_hold_r;
      end
    end else begin
      state_nxt_s = state_r;
      index_nxt_s = index_r;
    end
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r     <= '0;
      state_r     <= DE_IDLE;
      inst_hold_r <= '0;
    end else begin
      index_r     <= index_nxt_s;
      state_r     <= state_nxt_s;
      inst_hold_r <= inst_hold_nxt_s;
    end
  end

  // Protocol checks on decoder output, instruction shape and CQ stability
  always_ff @(posedge clk) begin
    if (!rst && inst_valid_cq2de && !trap_flush_rvv) begin
      assert (contiguous_s)
        else $error("decode_seq: non-contiguous dec_uop_valid %b", dec_uop_valid);
      assert (!drop_s)
        else $error("decode_seq: zero-uop instruction dropped");
      assert (done_s || ({1'b0, index_r} + 4'(n_push_s) <= 4'd7))
        else $error("decode_seq: uop index wrap idx=%0d n_push=%0d", index_r, n_push_s);
      assert ((state_r != DE_MID) || (inst_cq2de == inst_hold_r))
        else $error("decode_seq: CQ head changed mid-instruction");
    end
  end

endmodule

// File: tb/tb_rvv_backend_decode_seq.sv
// Directed self-checking bench for the RVV decode sequencer.
module tb_rvv_backend_decode_seq;
  import rvv_backend_decode_seq_pkg::*;

  logic                            clk;
  logic                            rst;
  logic                            inst_valid_cq2de;
  RVVCmd                           inst_cq2de;
  logic                            pop_de2cq;
  logic [UOP_INDEX_WIDTH-1:0]      uop_index_remain;
  logic [NUM_DE_UOP-1:0]           dec_uop_valid;
  logic [NUM_DE_UOP-1:0]           dec_uop_last;
  UOP_QUEUE_t [NUM_DE_UOP-1:0]     dec_uop;
  logic [UQ_FREE_WIDTH-1:0]        uq_free;
  logic [NUM_DE_UOP-1:0]           uop_valid_de2uq;
  UOP_QUEUE_t [NUM_DE_UOP-1:0]     uop_de2uq;
  logic                            trap_flush_rvv;
  logic                            busy;

  int n_assert;
  int n_fail;

  rvv_backend_decode_seq dut (
    .clk              (clk),
    .rst              (rst),
    .inst_valid_cq2de (inst_valid_cq2de),
    .inst_cq2de       (inst_cq2de),
    .pop_de2cq        (pop_de2cq),
    .uop_index_remain (uop_index_remain),
    .dec_uop_valid    (dec_uop_valid),
    .dec_uop_last     (dec_uop_last),
    .dec_uop          (dec_uop),
    .uq_free          (uq_free),
    .uop_valid_de2uq  (uop_valid_de2uq),
    .uop_de2uq        (uop_de2uq),
    .trap_flush_rvv   (trap_flush_rvv),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic UOP_QUEUE_t mk_uop(input logic [2:0] idx, input logic last);
    UOP_QUEUE_t u;
    u.opcode    = 7'h57;
    u.vd        = {2'b00, idx};
    u.uop_index = idx;
    u.last      = last;
    return u;
  endfunction

  // Expected UQ data: decoder lanes under mask, zero elsewhere
  function automatic logic [63:0] exp_uops(input logic [3:0] mask, input logic [2:0] idx,
                                           input logic [3:0] last);
    UOP_QUEUE_t [NUM_DE_UOP-1:0] e;
    e = '0;
    for (int k = 0; k < NUM_DE_UOP; k++) begin
      if (mask[k]) e[k] = mk_uop(idx + 3'(k), last[k]);
    end
    return 64'(e);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model the decoder: valid lanes carry uops idx+k, invalid lanes carry junk
  task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                       input logic [3:0] free, input logic [2:0] idx);
    dec_uop_valid = valid;
    dec_uop_last  = last;
    uq_free       = free;
    for (int k = 0; k < NUM_DE_UOP; k++) begin
      if (valid[k]) dec_uop[k] = mk_uop(idx + 3'(k), last[k]);
      else          dec_uop[k] = 16'hBEEF;
    end
  endtask

  task automatic set_inst(input logic [6:0] op, input logic [4:0] vd);
    inst_cq2de        = '0;
    inst_cq2de.opcode = op;
    inst_cq2de.vd     = vd;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst = 1'b1;
    inst_valid_cq2de = 1'b0;
    trap_flush_rvv = 1'b0;
    set_inst(7'h57, 5'd1);
    drive(4'b0000, 4'b0000, 4'd8, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rst_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("rst_busy", 64'(busy),             64'(1'b0));
    chk("rst_pop",  64'(pop_de2cq),        64'(1'b0));
    chk("rst_push", 64'(uop_valid_de2uq),  64'(4'b0000));
    chk("rst_uops", 64'(uop_de2uq),        64'd0);
    @(posedge clk); #1;

    // 3-uop instruction in one cycle
    inst_valid_cq2de = 1'b1;
    drive(4'b0111, 4'b0100, 4'd8, 3'd0);
    #4;
    chk("t3_push", 64'(uop_valid_de2uq), 64'(4'b0111));
    chk("t3_pop",  64'(pop_de2cq),       64'(1'b1));
    chk("t3_uops", 64'(uop_de2uq),       exp_uops(4'b0111, 3'd0, 4'b0100));
    @(posedge clk); #1;
    chk("t3_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("t3_busy", 64'(busy),             64'(1'b0));

    // 8-uop instruction over two cycles, ample free space
    set_inst(7'h57, 5'd2);
    drive(4'b1111, 4'b0000, 4'd15, 3'd0);
    #4;
    chk("t8a_push", 64'(uop_valid_de2uq), 64'(4'b1111));
    chk("t8a_pop",  64'(pop_de2cq),       64'(1'b0));
    @(posedge clk); #1;
    chk("t8a_idx",  64'(uop_index_remain), 64'(3'd4));
    chk("t8a_busy", 64'(busy),             64'(1'b1));
    drive(4'b1111, 4'b1000, 4'd8, 3'd4);
    #4;
    chk("t8b_push", 64'(uop_valid_de2uq), 64'(4'b1111));
    chk("t8b_pop",  64'(pop_de2cq),       64'(1'b1));
    chk("t8b_uops", 64'(uop_de2uq),       exp_uops(4'b1111, 3'd4, 4'b1000));
    @(posedge clk); #1;
    chk("t8b_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("t8b_busy", 64'(busy),             64'(1'b0));

    // 4-uop instruction throttled by uq_free 2,0,2
    set_inst(7'h57, 5'd3);
    drive(4'b1111, 4'b1000, 4'd2, 3'd0);
    #4;
    chk("thr0_push", 64'(uop_valid_de2uq), 64'(4'b0011));
    chk("thr0_pop",  64'(pop_de2cq),       64'(1'b0));
    chk("thr0_uops", 64'(uop_de2uq),       exp_uops(4'b0011, 3'd0, 4'b1000));
    @(posedge clk); #1;
    chk("thr0_idx",  64'(uop_index_remain), 64'(3'd2));
    drive(4'b0011, 4'b0010, 4'd0, 3'd2);
    #4;
    chk("thr1_push", 64'(uop_valid_de2uq), 64'(4'b0000));
    chk("thr1_pop",  64'(pop_de2cq),       64'(1'b0));
    chk("thr1_uops", 64'(uop_de2uq),       64'd0);
    @(posedge clk); #1;
    chk("thr1_idx",  64'(uop_index_remain), 64'(3'd2));
    chk("thr1_busy", 64'(busy),             64'(1'b1));
    drive(4'b0011, 4'b0010, 4'd2, 3'd2);
    #4;
    chk("thr2_push", 64'(uop_valid_de2uq), 64'(4'b0011));
    chk("thr2_pop",  64'(pop_de2cq),       64'(1'b1));
    @(posedge clk); #1;
    chk("thr2_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("thr2_busy", 64'(busy),             64'(1'b0));

    // Flush in MID at index 4, then restart from uop 0
    set_inst(7'h57, 5'd4);
    drive(4'b1111, 4'b0000, 4'd8, 3'd0);
    @(posedge clk); #1;
    chk("fl_pre_idx", 64'(uop_index_remain), 64'(3'd4));
    trap_flush_rvv = 1'b1;
    drive(4'b1111, 4'b1000, 4'd8, 3'd4);
    #4;
    chk("fl_push", 64'(uop_valid_de2uq), 64'(4'b0000));
    chk("fl_pop",  64'(pop_de2cq),       64'(1'b0));
    chk("fl_uops", 64'(uop_de2uq),       64'd0);
    @(posedge clk); #1;
    trap_flush_rvv = 1'b0;
    chk("fl_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("fl_busy", 64'(busy),             64'(1'b0));
    drive(4'b1111, 4'b0000, 4'd8, 3'd0);
    #4;
    chk("fl_re_push", 64'(uop_valid_de2uq), 64'(4'b1111));
    chk("fl_re_uops", 64'(uop_de2uq),       exp_uops(4'b1111, 3'd0, 4'b0000));
    @(posedge clk); #1;
    chk("fl_re_idx",  64'(uop_index_remain), 64'(3'd4));
    chk("fl_re_busy", 64'(busy),             64'(1'b1));

    // CQ head momentarily invalid while MID: hold everything
    inst_valid_cq2de = 1'b0;
    drive(4'b1111, 4'b1000, 4'd8, 3'd4);
    #4;
    chk("hold_push", 64'(uop_valid_de2uq), 64'(4'b0000));
    chk("hold_pop",  64'(pop_de2cq),       64'(1'b0));
    @(posedge clk); #1;
    chk("hold_idx",  64'(uop_index_remain), 64'(3'd4));
    chk("hold_busy", 64'(busy),             64'(1'b1));

    // Reset while MID
    inst_valid_cq2de = 1'b1;
    rst = 1'b1;
    #4;
    chk("rstm_pop",  64'(pop_de2cq),       64'(1'b0));
    chk("rstm_push", 64'(uop_valid_de2uq), 64'(4'b0000));
    @(posedge clk); #1;
    rst = 1'b0;
    inst_valid_cq2de = 1'b0;
    #4;
    chk("rstm_idx",  64'(uop_index_remain), 64'(3'd0));
    chk("rstm_busy", 64'(busy),             64'(1'b0));
    chk("rstm_pop2", 64'(pop_de2cq),        64'(1'b0));
    chk("rstm_uops", 64'(uop_de2uq),        64'd0);
    @(posedge clk); #1;

    // Back-to-back single-uop instructions
    inst_valid_cq2de = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inst(7'h57, 5'(10 + i));
      drive(4'b0001, 4'b0001, 4'd4, 3'd0);
      #4;
      chk("b2b_push", 64'(uop_valid_de2uq), 64'(4'b0001));
      chk("b2b_pop",  64'(pop_de2cq),       64'(1'b1));
      @(posedge clk); #1;
      chk("b2b_idx",  64'(uop_index_remain), 64'(3'd0));
    end
    inst_valid_cq2de = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
